// File: rtl/ddfs_pkg.sv
// Shared constants and field-width helpers for the DDFS phase engine.
package ddfs_pkg;

    localparam int unsigned OCT_W = 3;

    localparam int unsigned LFSR_W = 16;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5.
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

    function automatic int unsigned lut_width(int unsigned n, int unsigned l);
        return (l < n - OCT_W) ? l : n - OCT_W;
    endfunction

    function automatic int unsigned rot_width(int unsigned n, int unsigned l);
        return n - OCT_W - l;
    endfunction

    function automatic int unsigned dither_width(int unsigned acc_w, int unsigned n);
        return (acc_w - n > LFSR_W) ? LFSR_W : acc_w - n;
    endfunction

endpackage

// File: rtl/ddfs_phase_engine_if.sv
// Control, configuration and phase-field output bundle of the DDFS phase engine.
interface ddfs_phase_engine_if #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned N     = 18,
    parameter int unsigned L     = 6,
    parameter int unsigned CH_W  = 2
);
    import ddfs_pkg::*;

    logic                          en;
    logic                          sync_clr;
    logic                          cfg_we;
    logic [CH_W-1:0]               cfg_ch;
    logic [ACC_W-1:0]              cfg_fcw;
    logic [ACC_W-1:0]              cfg_poff;
    logic                          out_valid;
    logic [CH_W-1:0]               out_ch;
    logic [OCT_W-1:0]              phi_r;
    logic [lut_width(N, L)-1:0]    phi_lut;
    logic [rot_width(N, L)-1:0]    phi_rot;

    modport master (
        output en, sync_clr, cfg_we, cfg_ch, cfg_fcw, cfg_poff,
        input  out_valid, out_ch, phi_r, phi_lut, phi_rot
    );

    modport slave (
        input  en, sync_clr, cfg_we, cfg_ch, cfg_fcw, cfg_poff,
        output out_valid, out_ch, phi_r, phi_lut, phi_rot
    );

endinterface

// File: rtl/ddfs_octant_fold.sv
// Splits a truncated phase into octant, LUT address and rotation residual, folding odd octants.
module ddfs_octant_fold
    import ddfs_pkg::*;
#(
    parameter int unsigned N = 18,
    parameter int unsigned L = 6
) (
    input  logic [N-1:0]               phi,
    output logic [OCT_W-1:0]           r,
    output logic [lut_width(N, L)-1:0] lut,
    output logic [rot_width(N, L)-1:0] rot
);

    localparam int unsigned SW = N - OCT_W;
    localparam int unsigned RW = rot_width(N, L);

    logic [SW-1:0] s;

    // Odd octants mirror the quarter-wave, so the in-octant offset is complemented.
    assign s   = phi[SW-1:0] ^ {SW{phi[SW]}};
    assign r   = phi[N-1 -: OCT_W];
    assign lut = s[SW-1 -: L];
    assign rot = s[RW-1:0];

endmodule

// File: rtl/ddfs_phase_engine.sv
// Round-robin multi-channel phase accumulator with a two-stage octant-mapping pipeline.
// Optional LFSR phase dither is built when PT_DITHER_EN is defined.
module ddfs_phase_engine
    import ddfs_pkg::*;
#(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned N     = 18,
    parameter int unsigned L     = 6,
    parameter int unsigned NCH   = 4
) (
    input logic            clk,
    input logic            rst,
    ddfs_phase_engine_if.slave bus
);

    localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned RW   = rot_width(N, L);

    logic [ACC_W-1:0] acc_q  [NCH];
    logic [ACC_W-1:0] fcw_q  [NCH];
    logic [ACC_W-1:0] poff_q [NCH];
    logic [CH_W-1:0]  ptr_q, ptr_nxt;
    logic [ACC_W-1:0] acc_sel, fcw_sel, poff_sel, dither, sum;
    logic             issue;

    logic [N-1:0]     s1_phi_q;
    logic             s1_valid_q;
    logic [CH_W-1:0]  s1_ch_q;

    logic [OCT_W-1:0] fold_r, phi_r_q;
    logic [L-1:0]     fold_lut, phi_lut_q;
    logic [RW-1:0]    fold_rot, phi_rot_q;
    logic             out_valid_q;
    logic [CH_W-1:0]  out_ch_q;

    assign issue   = bus.en & ~bus.sync_clr;
    assign ptr_nxt = (ptr_q == CH_W'(NCH - 1)) ? '0 : ptr_q + CH_W'(1);

    always_comb begin
        acc_sel  = '0;
        fcw_sel  = '0;
        poff_sel = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ptr_q == CH_W'(i)) begin
                acc_sel  = acc_q[i];
                fcw_sel  = fcw_q[i];
                poff_sel = poff_q[i];
            end
        end
    end

`ifdef PT_DITHER_EN
    localparam int unsigned DW = dither_width(ACC_W, N);

    logic [LFSR_W-1:0] lfsr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else if (bus.sync_clr) begin
            lfsr_q <= LFSR_SEED;
        end else if (issue) begin
            lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[LFSR_W-1:1]};
        end
    end

    if (DW > 0) begin : g_dither
        assign dither = ACC_W'(lfsr_q[DW-1:0]);
    end else begin : g_no_dither
        assign dither = '0;
    end
`else
    assign dither = '0;
`endif

    assign sum = acc_sel + poff_sel + dither;

    // Config writes land even during sync_clr; an issue in the same cycle sees the old values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                acc_q[i]  <= '0;
                fcw_q[i]  <= '0;
                poff_q[i] <= '0;
            end
            ptr_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (bus.sync_clr) begin
                    acc_q[i] <= '0;
                end else if (issue && ptr_q == CH_W'(i)) begin
                    acc_q[i] <= acc_q[i] + fcw_q[i];
                end
                if (bus.cfg_we && bus.cfg_ch == CH_W'(i)) begin
                    fcw_q[i]  <= bus.cfg_fcw;
                    poff_q[i] <= bus.cfg_poff;
                end
            end
            if (bus.sync_clr) begin
                ptr_q <= '0;
            end else if (issue) begin
                ptr_q <= ptr_nxt;
            end
        end
    end

    // Only the truncated phase is kept; the low accumulator bits never reach the outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_phi_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_ch_q    <= '0;
        end else begin
            s1_valid_q <= issue;
            if (issue) begin
                s1_phi_q <= N'(sum >> (ACC_W - N));
                s1_ch_q  <= ptr_q;
            end
        end
    end

    ddfs_octant_fold #(
        .N (N),
        .L (L)
    ) u_fold (
        .phi (s1_phi_q),
        .r   (fold_r),
        .lut (fold_lut),
        .rot (fold_rot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            phi_r_q     <= '0;
            phi_lut_q   <= '0;
            phi_rot_q   <= '0;
        end else begin
            out_valid_q <= s1_valid_q & ~bus.sync_clr;
            if (s1_valid_q && !bus.sync_clr) begin
                out_ch_q  <= s1_ch_q;
                phi_r_q   <= fold_r;
                phi_lut_q <= fold_lut;
                phi_rot_q <= fold_rot;
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.phi_r     = phi_r_q;
    assign bus.phi_lut   = phi_lut_q;
    assign bus.phi_rot   = phi_rot_q;

endmodule

// File: tb/tb_ddfs_phase_engine.sv
// Directed bench for ddfs_phase_engine: a 4-channel and a 1-channel instance.
module tb_ddfs_phase_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ddfs_phase_engine_if #(.ACC_W(32), .N(18), .L(6), .CH_W(2)) bus4 ();
    ddfs_phase_engine_if #(.ACC_W(32), .N(18), .L(6), .CH_W(1)) bus1 ();

    ddfs_phase_engine #(.ACC_W(32), .N(18), .L(6), .NCH(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    ddfs_phase_engine #(.ACC_W(32), .N(18), .L(6), .NCH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    logic [17:0] f4;
    assign f4 = {bus4.phi_r, bus4.phi_lut, bus4.phi_rot};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus4.en = 0; bus4.sync_clr = 0; bus4.cfg_we = 0; bus4.cfg_ch = '0;
        bus4.cfg_fcw = '0; bus4.cfg_poff = '0;
        bus1.en = 0; bus1.sync_clr = 0; bus1.cfg_we = 0; bus1.cfg_ch = '0;
        bus1.cfg_fcw = '0; bus1.cfg_poff = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic cfg4(input logic [1:0] ch, input logic [31:0] fcw, input logic [31:0] poff);
        bus4.cfg_we = 1; bus4.cfg_ch = ch; bus4.cfg_fcw = fcw; bus4.cfg_poff = poff;
        step();
        bus4.cfg_we = 0;
    endtask

    task automatic cfg1(input logic ch, input logic [31:0] fcw, input logic [31:0] poff);
        bus1.cfg_we = 1; bus1.cfg_ch = ch; bus1.cfg_fcw = fcw; bus1.cfg_poff = poff;
        step();
        bus1.cfg_we = 0;
    endtask

    task automatic test_reset();
        do_reset();
        cfg4(2'd0, 32'h0100_0000, 32'h0);
        bus4.en = 1;
        for (int i = 0; i < 6; i++) step();
        // Output j=4 is ch0's second service: phi = 0x00400.
        n_cmp++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd0 || f4 !== {3'd0, 6'd2, 9'd0}) begin
            n_bad++;
            $display("FAIL reset_pre: got v=%b ch=%0d f=%h want v=1 ch=0 f=%h",
                     bus4.out_valid, bus4.out_ch, f4, {3'd0, 6'd2, 9'd0});
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (bus4.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid: got %b want 0", bus4.out_valid);
        end
        n_cmp++;
        if (bus4.out_ch !== 2'd0 || f4 !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_fields: got ch=%0d f=%h want ch=0 f=0", bus4.out_ch, f4);
        end
        step();
        rst = 1'b0;
        step();
        n_cmp++;
        if (bus4.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_lat1: got v=%b want 0", bus4.out_valid);
        end
        step();
        n_cmp++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd0 || f4 !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_first: got v=%b ch=%0d f=%h want v=1 ch=0 f=0",
                     bus4.out_valid, bus4.out_ch, f4);
        end
        bus4.en = 0;
    endtask

    task automatic test_round_robin();
        do_reset();
        cfg4(2'd0, 32'h0100_0000, 32'h0);
        bus4.en = 1;
        step();
        for (int j = 0; j < 16; j++) begin
            step();
            n_cmp++;
            if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'(j % 4)) begin
                n_bad++;
                $display("FAIL rr_ch[%0d]: got v=%b ch=%0d want v=1 ch=%0d",
                         j, bus4.out_valid, bus4.out_ch, j % 4);
            end
            if (j % 4 == 0) begin
                n_cmp++;
                if (f4 !== {3'd0, 6'(2 * (j / 4)), 9'd0}) begin
                    n_bad++;
                    $display("FAIL rr_phi[%0d]: got %h want %h", j, f4,
                             {3'd0, 6'(2 * (j / 4)), 9'd0});
                end
            end
        end
        bus4.en = 0;
    endtask

    task automatic test_fold();
        do_reset();
        cfg4(2'd1, 32'h0, 32'h2000_0000);
        bus4.en = 1;
        step();
        step();
        step();
        n_cmp++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd1 || f4 !== {3'b001, 6'h3F, 9'h1FF}) begin
            n_bad++;
            $display("FAIL fold_oct1: got v=%b ch=%0d f=%h want v=1 ch=1 f=%h",
                     bus4.out_valid, bus4.out_ch, f4, {3'b001, 6'h3F, 9'h1FF});
        end
        bus4.en = 0;
        cfg4(2'd1, 32'h0, 32'h4000_0000);
        bus4.sync_clr = 1;
        step();
        bus4.sync_clr = 0;
        bus4.en = 1;
        step();
        step();
        step();
        n_cmp++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd1 || f4 !== {3'b010, 6'h0, 9'h0}) begin
            n_bad++;
            $display("FAIL fold_oct2: got v=%b ch=%0d f=%h want v=1 ch=1 f=%h",
                     bus4.out_valid, bus4.out_ch, f4, {3'b010, 6'h0, 9'h0});
        end
        bus4.en = 0;
    endtask

    task automatic test_wrap();
        logic [2:0] exp_r [5];
        exp_r = '{3'b000, 3'b110, 3'b100, 3'b010, 3'b000};
        do_reset();
        cfg1(1'b0, 32'hC000_0000, 32'h0);
        // Channel 1 does not exist with one channel; this write must not touch channel 0.
        cfg1(1'b1, 32'h4000_0000, 32'h2000_0000);
        bus1.en = 1;
        step();
        for (int k = 0; k < 5; k++) begin
            step();
            n_cmp++;
            if (bus1.out_valid !== 1'b1 || bus1.out_ch !== 1'b0 || bus1.phi_r !== exp_r[k]) begin
                n_bad++;
                $display("FAIL wrap[%0d]: got v=%b ch=%0d r=%b want v=1 ch=0 r=%b",
                         k, bus1.out_valid, bus1.out_ch, bus1.phi_r, exp_r[k]);
            end
        end
        bus1.en = 0;
    endtask

    task automatic test_collision();
        logic [5:0] exp_lut [3];
        int         n_seen;
        exp_lut = '{6'd0, 6'd2, 6'd6};
        n_seen  = 0;
        do_reset();
        cfg4(2'd2, 32'h0100_0000, 32'h0);
        bus4.en = 1;
        for (int e = 1; e <= 12; e++) begin
            if (e == 3) begin
                bus4.cfg_we = 1; bus4.cfg_ch = 2'd2;
                bus4.cfg_fcw = 32'h0200_0000; bus4.cfg_poff = 32'h0;
            end
            step();
            bus4.cfg_we = 0;
            if (e % 4 == 0) begin
                n_cmp++;
                if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd2 ||
                    f4 !== {3'd0, exp_lut[n_seen], 9'd0}) begin
                    n_bad++;
                    $display("FAIL collide[%0d]: got v=%b ch=%0d f=%h want v=1 ch=2 f=%h",
                             n_seen, bus4.out_valid, bus4.out_ch, f4,
                             {3'd0, exp_lut[n_seen], 9'd0});
                end
                n_seen++;
            end
        end
        bus4.en = 0;
    endtask

    task automatic test_sync_clr();
        do_reset();
        cfg4(2'd0, 32'h0100_0000, 32'h1234_5678);
        bus4.en = 1;
        for (int i = 0; i < 6; i++) step();
        bus4.sync_clr = 1;
        step();
        bus4.sync_clr = 0;
        n_cmp++;
        if (bus4.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_bubble0: got v=%b want 0", bus4.out_valid);
        end
        step();
        n_cmp++;
        if (bus4.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_bubble1: got v=%b want 0", bus4.out_valid);
        end
        step();
        n_cmp++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd0 || f4 !== {3'd0, 6'h24, 9'h0D1}) begin
            n_bad++;
            $display("FAIL clr_first: got v=%b ch=%0d f=%h want v=1 ch=0 f=%h",
                     bus4.out_valid, bus4.out_ch, f4, {3'd0, 6'h24, 9'h0D1});
        end
        for (int i = 0; i < 4; i++) step();
        // FCW survives the clear: second service is (fcw + poff) truncated.
        n_cmp++;
        if (bus4.out_valid !== 1'b1 || bus4.out_ch !== 2'd0 || f4 !== {3'd0, 6'h26, 9'h0D1}) begin
            n_bad++;
            $display("FAIL clr_second: got v=%b ch=%0d f=%h want v=1 ch=0 f=%h",
                     bus4.out_valid, bus4.out_ch, f4, {3'd0, 6'h26, 9'h0D1});
        end
        bus4.en = 0;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_fold();
        test_wrap();
        test_collision();
        test_sync_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "time limit");
    end

endmodule
